// File: rtl/grid_pkg.sv
// ---------------------------------------------------------------------------
// grid_pkg
// Shared definitions for the bubble-grid renderer: RGB565 palette constants,
// bus widths, default cell-code width and the palette decode function.
// No ports (package).
// ---------------------------------------------------------------------------
package grid_pkg;

    // Default number of bits per cell code (MSB = blink flag)
    localparam int CODE_W_DEF = 5;

    // Pixel bus widths shared by the interface and the renderer
    localparam int COORD_W = 8;
    localparam int PIX_W   = 16;

    // RGB565 colours
    localparam logic [PIX_W-1:0] BUBBLE_R = 16'hfaac;
    localparam logic [PIX_W-1:0] BUBBLE_G = 16'h8760;
    localparam logic [PIX_W-1:0] BUBBLE_B = 16'h351f;
    localparam logic [PIX_W-1:0] BUBBLE_W = 16'hffff;
    localparam logic [PIX_W-1:0] PLAYER_C = 16'hfcc0;
    localparam logic [PIX_W-1:0] BLACK    = 16'h0000;

    // Palette slots addressed by the low bits of a cell code
    typedef enum logic [1:0] {
        PAL_R = 2'd0,
        PAL_G = 2'd1,
        PAL_B = 2'd2,
        PAL_W = 2'd3
    } palette_e;

    // Decode a (zero-extended) palette index into RGB565; anything past the
    // four defined slots renders as black.
    function automatic logic [PIX_W-1:0] palette_decode(input logic [15:0] idx);
        logic [PIX_W-1:0] rgb;
        rgb = BLACK;
        if (idx[15:2] == 14'd0) begin
            case (palette_e'(idx[1:0]))
                PAL_R:   rgb = BUBBLE_R;
                PAL_G:   rgb = BUBBLE_G;
                PAL_B:   rgb = BUBBLE_B;
                PAL_W:   rgb = BUBBLE_W;
                default: rgb = BLACK;
            endcase
        end
        return rgb;
    endfunction

endpackage

// File: rtl/grid_renderer_if.sv
// ---------------------------------------------------------------------------
// grid_renderer_if
// Pixel request/response bus between the LCD streamer and the renderer.
//   req_valid : pixel request strobe (one request per cycle allowed)
//   req_x     : requested pixel column
//   req_y     : requested pixel row
//   pix_valid : response strobe, fixed latency after req_valid
//   pix_data  : RGB565 response pixel
// Modports: master = streamer side, slave = renderer side.
// ---------------------------------------------------------------------------
interface grid_renderer_if;
    import grid_pkg::*;

    logic               req_valid;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic               pix_valid;
    logic [PIX_W-1:0]   pix_data;

    modport master (
        output req_valid, req_x, req_y,
        input  pix_valid, pix_data
    );

    modport slave (
        input  req_valid, req_x, req_y,
        output pix_valid, pix_data
    );

endinterface

// File: rtl/grid_palette.sv
// ---------------------------------------------------------------------------
// grid_palette
// Combinational lookup from the colour bits of a cell code to RGB565.
//   idx : low CODE_W-1 bits of the cell code (blink flag stripped)
//   rgb : RGB565 colour
// ---------------------------------------------------------------------------
module grid_palette
    import grid_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [CODE_W-2:0] idx,
    output logic [PIX_W-1:0]  rgb
);

    // Zero-extend the index so the package decoder sees one fixed width
    always_comb begin
        rgb = palette_decode(16'(idx));
    end

endmodule

// File: rtl/grid_renderer.sv
// ---------------------------------------------------------------------------
// grid_renderer
// Renders a ROWS x COLS bubble grid for the 128x160 LCD. Cell codes arrive
// into a shadow copy and are committed to the active board at frame start,
// so a frame never mixes two boards. Pixel requests are answered with
// RGB565 after a fixed two-cycle pipeline, with a player overlay and
// blinking cells applied on top of the palette colour.
//   clk, rst_n   : clock, asynchronous active-low reset
//   grid_in      : packed cell codes, cell (r,c) at (r*COLS+c)*CODE_W
//   grid_load    : capture grid_in into the shadow board
//   frame_start  : frame boundary; commits a pending shadow board
//   player_row/col, player_en : player overlay cell and enable
//   pix_bus      : pixel request/response bus (slave side)
//   pending      : shadow holds data not yet committed
// ---------------------------------------------------------------------------
module grid_renderer
    import grid_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int CELL_LOG2  = 4,
    parameter int X_OFF      = 0,
    parameter int Y_OFF      = 16,
    parameter int CODE_W     = CODE_W_DEF,
    parameter int BLINK_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ROWS*COLS*CODE_W-1:0] grid_in,
    input  logic                       grid_load,
    input  logic                       frame_start,
    input  logic [7:0]                 player_row,
    input  logic [7:0]                 player_col,
    input  logic                       player_en,
    grid_renderer_if.slave             pix_bus,
    output logic                       pending
);

    localparam int CELLS   = ROWS * COLS;
    localparam int GRID_W  = CELLS * CODE_W;
    localparam int WIN_W   = COLS << CELL_LOG2;
    localparam int WIN_H   = ROWS << CELL_LOG2;
    localparam int CELL_PX = 1 << CELL_LOG2;

    localparam logic [8:0]           X_OFF9 = 9'(X_OFF);
    localparam logic [8:0]           Y_OFF9 = 9'(Y_OFF);
    localparam logic [CELL_LOG2-1:0] SUB_LO = CELL_LOG2'(2);
    localparam logic [CELL_LOG2-1:0] SUB_HI = CELL_LOG2'(CELL_PX - 3);

    logic [GRID_W-1:0]     shadow;
    logic [GRID_W-1:0]     active;
    logic [BLINK_LOG2:0]   frame_cnt;

    // Stage-1 combinational decode
    logic [8:0]            dx;
    logic [8:0]            dy;
    logic                  win;
    logic [7:0]            row_c;
    logic [7:0]            col_c;
    int                    cell_idx;
    logic [CODE_W-1:0]     code_c;

    // Stage-1 registers
    logic                  s1_valid;
    logic                  s1_win;
    logic [7:0]            s1_row;
    logic [7:0]            s1_col;
    logic [CELL_LOG2-1:0]  s1_sub_x;
    logic [CELL_LOG2-1:0]  s1_sub_y;
    logic [CODE_W-1:0]     s1_code;

    // Stage-2 combinational colour selection
    logic                  sub_ok;
    logic                  player_hit;
    logic                  blink_off;
    logic [PIX_W-1:0]      pal_rgb;
    logic [PIX_W-1:0]      pix_next;

    // Board double-buffering and frame counting. The commit reads the old
    // shadow (non-blocking), so a load coinciding with frame_start lands in
    // the shadow and keeps pending set for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            active    <= '0;
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (grid_load) begin
                shadow <= grid_in;
            end
            if (frame_start && pending) begin
                active <= shadow;
            end
            if (grid_load) begin
                pending <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
            if (frame_start) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Map the request into grid coordinates. Offsets are taken at 9 bits so
    // a coordinate left of / above the window wraps to a large value and
    // fails the window test instead of aliasing into the grid.
    always_comb begin
        dx       = {1'b0, pix_bus.req_x} - X_OFF9;
        dy       = {1'b0, pix_bus.req_y} - Y_OFF9;
        win      = ({23'd0, dx} < WIN_W) && ({23'd0, dy} < WIN_H);
        col_c    = 8'(dx >> CELL_LOG2);
        row_c    = 8'(dy >> CELL_LOG2);
        cell_idx = int'(row_c) * COLS + int'(col_c);
        code_c   = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (win && (cell_idx == i)) begin
                code_c = active[i*CODE_W +: CODE_W];
            end
        end
    end

    // Stage 1 captures the cell code, so a commit arriving while the pixel
    // is in flight cannot change its colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_win   <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_sub_x <= '0;
            s1_sub_y <= '0;
            s1_code  <= '0;
        end else begin
            s1_valid <= pix_bus.req_valid;
            if (pix_bus.req_valid) begin
                s1_win   <= win;
                s1_row   <= row_c;
                s1_col   <= col_c;
                s1_sub_x <= dx[CELL_LOG2-1:0];
                s1_sub_y <= dy[CELL_LOG2-1:0];
                s1_code  <= code_c;
            end
        end
    end

    grid_palette #(
        .CODE_W (CODE_W)
    ) u_palette (
        .idx (s1_code[CODE_W-2:0]),
        .rgb (pal_rgb)
    );

    // Colour priority: outside window, player marker (inset two pixels from
    // the cell edge), blink-off phase, then palette colour. Player cells
    // outside the grid cannot match because out-of-window wins first.
    always_comb begin
        pix_next   = BLACK;
        sub_ok     = (s1_sub_x >= SUB_LO) && (s1_sub_x <= SUB_HI) &&
                     (s1_sub_y >= SUB_LO) && (s1_sub_y <= SUB_HI);
        player_hit = player_en && (s1_row == player_row) &&
                     (s1_col == player_col) && sub_ok;
        blink_off  = s1_code[CODE_W-1] && frame_cnt[BLINK_LOG2];
        if (!s1_win) begin
            pix_next = BLACK;
        end else if (player_hit) begin
            pix_next = PLAYER_C;
        end else if (blink_off) begin
            pix_next = BLACK;
        end else begin
            pix_next = pal_rgb;
        end
    end

    // Output register; pix_data holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_bus.pix_valid <= 1'b0;
            pix_bus.pix_data  <= '0;
        end else begin
            pix_bus.pix_valid <= s1_valid;
            if (s1_valid) begin
                pix_bus.pix_data <= pix_next;
            end
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// ---------------------------------------------------------------------------
// tb_grid_renderer
// Self-checking bench for grid_renderer. A board-level model (2-D arrays of
// cell codes, a pending flag and a frame count) predicts every pixel from
// the rendering rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_grid_renderer;
    import grid_pkg::*;

    localparam int COLS   = 8;
    localparam int ROWS   = 8;
    localparam int CELL   = 16;
    localparam int X_OFF  = 0;
    localparam int Y_OFF  = 16;
    localparam int CODE_W = 5;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [ROWS*COLS*CODE_W-1:0] grid_in = '0;
    logic                        grid_load = 1'b0;
    logic                        frame_start = 1'b0;
    logic [7:0]                  player_row = '0;
    logic [7:0]                  player_col = '0;
    logic                        player_en = 1'b0;
    logic                        pending;

    grid_renderer_if bus ();

    grid_renderer #(
        .COLS(COLS), .ROWS(ROWS), .CELL_LOG2(4), .X_OFF(X_OFF),
        .Y_OFF(Y_OFF), .CODE_W(CODE_W), .BLINK_LOG2(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .grid_in     (grid_in),
        .grid_load   (grid_load),
        .frame_start (frame_start),
        .player_row  (player_row),
        .player_col  (player_col),
        .player_en   (player_en),
        .pix_bus     (bus),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_active [ROWS][COLS];
    int m_shadow [ROWS][COLS];
    int nb       [ROWS][COLS];
    bit m_pending;
    int m_frames;

    int checks = 0;
    int errors = 0;

    function automatic void model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m_active[r][c] = 0;
                m_shadow[r][c] = 0;
            end
        m_pending = 1'b0;
        m_frames  = 0;
    endfunction

    function automatic logic [ROWS*COLS*CODE_W-1:0] pack_board();
        logic [ROWS*COLS*CODE_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*CODE_W +: CODE_W] = CODE_W'(nb[r][c]);
        return v;
    endfunction

    function automatic void random_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                nb[r][c] = int'($urandom_range(0, 31));
    endfunction

    function automatic void clear_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                nb[r][c] = 0;
    endfunction

    // Expected colour of pixel (x,y) from the rendering rules
    function automatic logic [15:0] exp_pix(int x, int y);
        int gx, gy, r, c, sx, sy, code;
        gx = x - X_OFF;
        gy = y - Y_OFF;
        if (gx < 0 || gy < 0 || gx >= COLS*CELL || gy >= ROWS*CELL) return 16'h0000;
        r  = gy / CELL;
        c  = gx / CELL;
        sx = gx % CELL;
        sy = gy % CELL;
        if (player_en && r == int'(player_row) && c == int'(player_col) &&
            sx >= 2 && sx <= CELL-3 && sy >= 2 && sy <= CELL-3) return 16'hfcc0;
        code = m_active[r][c];
        if (code >= 16 && ((m_frames / 16) % 2) == 1) return 16'h0000;
        case (code % 16)
            0:       return 16'hfaac;
            1:       return 16'h8760;
            2:       return 16'h351f;
            3:       return 16'hffff;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Load nb into the shadow, optionally together with frame_start
    task automatic doLoad(input bit with_frame);
        grid_in     = pack_board();
        grid_load   = 1'b1;
        frame_start = with_frame;
        tick();
        grid_load   = 1'b0;
        frame_start = 1'b0;
        if (with_frame) begin
            if (m_pending) m_active = m_shadow;
            m_frames++;
        end
        m_shadow  = nb;
        m_pending = 1'b1;
    endtask

    task automatic doFrame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (m_pending) m_active = m_shadow;
        m_pending = 1'b0;
        m_frames++;
    endtask

    // Single isolated request: checks latency and colour
    task automatic applyStimulus(input int x, input int y, input string tag);
        logic [15:0] expected;
        expected      = exp_pix(x, y);
        bus.req_valid = 1'b1;
        bus.req_x     = 8'(x);
        bus.req_y     = 8'(y);
        tick();
        bus.req_valid = 1'b0;
        checkOutput({tag, "_early"}, {15'd0, bus.pix_valid}, 16'd0);
        tick();
        checkOutput({tag, "_valid"}, {15'd0, bus.pix_valid}, 16'd1);
        checkOutput(tag, bus.pix_data, expected);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] expq[$];
        int nvalid;
        int x, y;

        bus.req_valid = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        model_reset();

        // Reset state
        tick();
        tick();
        checkOutput("rst_pix_valid", {15'd0, bus.pix_valid}, 16'd0);
        checkOutput("rst_pix_data", bus.pix_data, 16'h0000);
        checkOutput("rst_pending", {15'd0, pending}, 16'd0);
        rst_n = 1'b1;
        tick();

        // First request on an all-zero board
        applyStimulus(0, 16, "zero_board");

        // Simple directed board
        clear_board();
        nb[0][0] = 1;
        nb[7][7] = 2;
        doLoad(1'b0);
        checkOutput("pending_after_load", {15'd0, pending}, {15'd0, m_pending});
        doFrame();
        checkOutput("pending_after_commit", {15'd0, pending}, {15'd0, m_pending});
        applyStimulus(5, 20, "cell00_green");
        applyStimulus(5, 10, "above_window");
        applyStimulus(127, 143, "cell77_blue");
        applyStimulus(128, 20, "right_of_window");
        applyStimulus(5, 144, "below_window");

        // New board loaded but not committed: reads see the old board
        random_board();
        doLoad(1'b0);
        checkOutput("pending_uncommitted", {15'd0, pending}, 16'd1);
        for (int i = 0; i < 4; i++)
            applyStimulus(int'($urandom_range(0, 127)), int'($urandom_range(16, 143)), "old_board");
        doFrame();
        checkOutput("pending_cleared", {15'd0, pending}, 16'd0);
        for (int i = 0; i < 4; i++)
            applyStimulus(int'($urandom_range(0, 127)), int'($urandom_range(16, 143)), "new_board");

        // Double load: last capture wins; then load coincident with frame_start
        random_board();
        doLoad(1'b0);
        random_board();
        doLoad(1'b0);
        random_board();
        doLoad(1'b1);
        checkOutput("pending_simul", {15'd0, pending}, 16'd1);
        for (int i = 0; i < 4; i++)
            applyStimulus(int'($urandom_range(0, 127)), int'($urandom_range(16, 143)), "simul_old_shadow");
        doFrame();
        checkOutput("pending_after_simul", {15'd0, pending}, 16'd0);
        for (int i = 0; i < 4; i++)
            applyStimulus(int'($urandom_range(0, 127)), int'($urandom_range(16, 143)), "simul_new_board");

        // Player overlay
        random_board();
        nb[3][4] = 3;
        doLoad(1'b0);
        doFrame();
        player_row = 8'd3;
        player_col = 8'd4;
        player_en  = 1'b1;
        applyStimulus(4*16+8, 16+3*16+8, "player_centre");
        applyStimulus(4*16+1, 16+3*16+8, "player_edge_subpix");
        applyStimulus(4*16+13, 16+3*16+2, "player_inner_corner");
        player_en = 1'b0;
        applyStimulus(4*16+8, 16+3*16+8, "player_disabled");

        // Blinking cell across 32 frames
        clear_board();
        nb[0][0] = 16;
        doLoad(1'b0);
        doFrame();
        applyStimulus(5, 20, "blink_start");
        for (int k = 1; k <= 32; k++) begin
            doFrame();
            if (k % 4 == 0) applyStimulus(5, 20, "blink_phase");
        end

        // Back-to-back random stream with the player overlay on
        random_board();
        doLoad(1'b0);
        doFrame();
        player_row = 8'($urandom_range(0, 7));
        player_col = 8'($urandom_range(0, 7));
        player_en  = 1'b1;
        nvalid = 0;
        for (int i = 0; i <= 161; i++) begin
            if (i < 160) begin
                x = int'($urandom_range(0, 140));
                y = int'($urandom_range(0, 159));
                bus.req_valid = 1'b1;
                bus.req_x     = 8'(x);
                bus.req_y     = 8'(y);
                expq.push_back(exp_pix(x, y));
            end else begin
                bus.req_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 160) begin
                checkOutput("stream_valid", {15'd0, bus.pix_valid}, 16'd1);
                if (bus.pix_valid) nvalid++;
                checkOutput("stream_data", bus.pix_data, expq.pop_front());
            end else begin
                checkOutput("stream_idle", {15'd0, bus.pix_valid}, 16'd0);
            end
        end
        checkOutput("stream_count", 16'(nvalid), 16'd160);

        // Reset asserted in the middle of a stream
        random_board();
        doLoad(1'b0);
        player_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_x     = 8'($urandom_range(0, 127));
            bus.req_y     = 8'($urandom_range(16, 143));
            tick();
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pix_valid", {15'd0, bus.pix_valid}, 16'd0);
        checkOutput("midrst_pix_data", bus.pix_data, 16'h0000);
        checkOutput("midrst_pending", {15'd0, pending}, 16'd0);
        bus.req_valid = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("postrst_pix_valid", {15'd0, bus.pix_valid}, 16'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(int'($urandom_range(0, 127)), int'($urandom_range(16, 143)), "cleared_board");
        doFrame();
        applyStimulus(64, 80, "cleared_after_frame");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
